// File: rtl/mux_rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mux_rr_arb_pkg
// Brief  : Shared types and constants for the 4:1 mux round-robin arbiter.
//          Holds the FSM state enum, requester count, select width and a
//          one-hot to index conversion helper.
// Rev    : 1.0  initial release
// ============================================================================
package mux_rr_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // OR-combines the indices of set bits; exact for a one-hot input and
  // free of any priority chain.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (oh[k]) idx = idx | SEL_W'(k);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority search. Scans mask starting at
//          index 'start', wrapping modulo NREQ; the first set bit wins.
// Ports  : mask  [3:0] in  - candidate requesters
//          start [1:0] in  - first index to examine
//          found       out - any bit of mask set
//          idx   [1:0] out - winning index (valid when found)
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick
  import mux_rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  mask,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = start + SEL_W'(k);
      if (mask[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mux_rr_arbiter
// Brief  : Round-robin arbiter / sequencer for the shared 4:1 1-bit mux.
//          Grants one requester at a time for at most SLICE cycles, drives
//          the mux select and registers the selected data bit onto y.
// Config : MUX_RR_ARB_LOCK_EN - adds 'lock' input; a locked owner that is
//          still requesting keeps the grant past its slice.
// Ports  : clk          in  - clock, rising edge
//          reset_n      in  - asynchronous active-low reset
//          req   [3:0]  in  - request per requester
//          d     [3:0]  in  - mux data inputs i0..i3
//          lock         in  - (MUX_RR_ARB_LOCK_EN only) hold grant
//          gnt   [3:0]  out - registered one-hot grant, 0 when idle
//          sel   [1:0]  out - registered mux select (holds when idle)
//          valid        out - registered OR of gnt
//          y            out - registered d[sel] while valid, else 0
// Rev    : 1.0  initial release
// ============================================================================
module mux_rr_arbiter
  import mux_rr_arb_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  d,
`ifdef MUX_RR_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             y
);

  localparam int                CNT_W   = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SLICE - 1);

  state_t           state, state_nx;
  logic [SEL_W-1:0] owner, owner_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [NREQ-1:0]  gnt_nx;
  logic [SEL_W-1:0] sel_nx;
  logic             valid_nx;
  logic             y_nx;

  logic             owner_req;
  logic             at_max;
  logic             hold;
  logic             release_vol;
  logic [NREQ-1:0]  pick_mask;
  logic [SEL_W-1:0] pick_start;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  assign owner_req   = req[owner];
  assign at_max      = (cnt == CNT_MAX);
  assign release_vol = (state == GRANT) && !owner_req;

`ifdef MUX_RR_ARB_LOCK_EN
  assign hold = lock && owner_req;
`else
  assign hold = 1'b0;
`endif

  // A voluntarily releasing owner is excluded from its own handover pick;
  // on slice expiry it stays in the mask and, scanning from owner+1, it can
  // only win when nobody else is requesting.
  assign pick_mask  = release_vol ? (req & ~(NREQ'(1) << owner)) : req;
  assign pick_start = owner + SEL_W'(1);

  rr_pick u_pick (
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nx = GRANT;
          owner_nx = pick_idx;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          cnt_nx = '0;
          if (pick_found) begin
            owner_nx = pick_idx;
          end else begin
            state_nx = IDLE;
          end
        end else if (at_max && !hold) begin
          owner_nx = pick_idx;
          cnt_nx   = '0;
        end else if (!at_max) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decision so the grant
  // lands one cycle after req is sampled with no handover bubble.
  always_comb begin
    valid_nx = (state_nx == GRANT);
    gnt_nx   = valid_nx ? (NREQ'(1) << owner_nx) : '0;
    sel_nx   = valid_nx ? onehot_to_idx(gnt_nx) : sel;
    y_nx     = valid_nx ? d[sel_nx] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= SEL_W'(NREQ - 1);
      cnt   <= '0;
      gnt   <= '0;
      sel   <= '0;
      valid <= 1'b0;
      y     <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      cnt   <= cnt_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      valid <= valid_nx;
      y     <= y_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_mux_rr_arbiter
// Brief  : Self-checking bench for mux_rr_arbiter (SLICE = 4). A tenure-based
//          reference model predicts gnt/sel/valid/y every cycle; directed
//          sequences pin literal values, then randomized req/d traffic runs.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mux_rr_arbiter;

  localparam int SLICE = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       y;
`ifdef MUX_RR_ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mux_rr_arbiter #(.SLICE(SLICE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .d       (d),
`ifdef MUX_RR_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .y       (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: tracks tenure length, not a counter
  int         m_owner = 3;
  bit         m_busy  = 1'b0;
  int         m_len   = 0;
  logic [3:0] m_gnt   = 4'b0;
  logic [1:0] m_sel   = 2'b0;
  logic       m_valid = 1'b0;
  logic       m_y     = 1'b0;

  function automatic int pick_after(input logic [3:0] mask, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = 3; m_busy = 1'b0; m_len = 0;
    m_gnt = 4'b0; m_sel = 2'b0; m_valid = 1'b0; m_y = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] dd);
    int w;
    bit fresh;
    fresh = 1'b1;
    if (!m_busy)               w = pick_after(r, m_owner);
    else if (!r[m_owner])      w = pick_after(r & ~(4'b0001 << m_owner), m_owner);
    else if (m_len >= SLICE)   w = pick_after(r, m_owner);
    else begin w = m_owner; fresh = 1'b0; end
    if (w < 0) begin
      m_busy = 1'b0; m_len = 0; m_gnt = 4'b0; m_valid = 1'b0; m_y = 1'b0;
    end else begin
      m_busy  = 1'b1;
      m_owner = w;
      m_len   = fresh ? 1 : m_len + 1;
      m_gnt   = 4'b0001 << w;
      m_sel   = 2'(w);
      m_valid = 1'b1;
      m_y     = dd[w];
    end
  endtask

  always @(negedge reset_n) model_reset();

  // Single compare process: advance the model at each edge, check 1 ns later.
  always @(posedge clk) begin
    if (!reset_n) model_reset();
    else          model_step(req, d);
    #1;
    check("gnt",   32'(gnt),   32'(m_gnt));
    check("sel",   32'(sel),   32'(m_sel));
    check("valid", 32'(valid), 32'(m_valid));
    check("y",     32'(y),     32'(m_y));
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req = 4'b0; d = 4'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic exp_y;

  initial begin
    reset_n = 1'b0; req = 4'b0; d = 4'b0;
    model_reset();
    #2;
    check("rst_gnt",   32'(gnt),   32'h0);
    check("rst_sel",   32'(sel),   32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_y",     32'(y),     32'h0);

    // First grant: scan starts at 0, so requester 1 of 1010 wins.
    @(negedge clk);
    reset_n = 1'b1; req = 4'b1010;
    @(negedge clk);
    check("first_gnt",   32'(gnt),   32'h2);
    check("first_sel",   32'(sel),   32'h1);
    check("first_valid", 32'(valid), 32'h1);

    // Fairness: all requesting, owners 0,1,2,3,0 for SLICE cycles each.
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("fair_gnt", 32'(gnt), 32'(4'b0001 << ((c / 4) % 4)));
    end

    // Voluntary release by owner 2 after two cycles, requester 0 waiting.
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    check("vol_gnt_c1", 32'(gnt), 32'h4);
    req = 4'b0101;
    @(negedge clk);
    check("vol_gnt_c2", 32'(gnt), 32'h4);
    req = 4'b0001;
    @(negedge clk);
    check("vol_handover", 32'(gnt), 32'h1);

    // Sole requester: continuous grant, y follows d[3] with one-cycle latency.
    do_reset();
    req = 4'b1000; d = 4'b1000; exp_y = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("sole_gnt", 32'(gnt), 32'h8);
      check("sole_y",   32'(y),   32'(exp_y));
      d[3]  = ~d[3];
      exp_y = d[3];
    end

    // Asynchronous reset between edges during a grant.
    @(negedge clk);
    #2;
    reset_n = 1'b0; req = 4'b0;
    #1;
    check("arst_gnt",   32'(gnt),   32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_y",     32'(y),     32'h0);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    check("arst_rescan", 32'(gnt), 32'h1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      d = 4'($urandom);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 select datapath. Four requesters compete for the shared 1-bit mux. The block grants one requester at a time for a bounded time slice and drives the mux select `sel`. It also registers the selected data bit onto `y`, replacing the free-running select counter with demand-driven scheduling.

## Interface
- `SLICE`, default 4: maximum consecutive grant cycles per ownership; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 4: request per requester; bit k corresponds to mux input ik.
- `d` input 4: data bits i0..i3 feeding the shared mux; bit k is ik.
- `lock` input 1: present only with `MUX_RR_ARB_LOCK_EN`; the owner holds the grant past its slice.
- `gnt` output 4: one-hot grant, registered; 4'b0000 when idle.
- `sel` output 2: mux select, registered; equals the index of the set `gnt` bit.
- `valid` output 1: registered; equals the OR of all `gnt` bits.
- `y` output 1: registered copy of `d[sel]` while valid, otherwise 0.

## Operation
- States: IDLE and GRANT.
- Internal registers:
  - `owner` (2 bits): index of the current or last grantee.
  - `cnt`: width is $clog2(SLICE), minimum 1 bit.
- Pick rule: scan the candidate mask starting at `owner+1` mod 4 and wrapping. The first set bit wins.
- IDLE:
  - `gnt` is 0 and `sel` holds its last value.
  - If `req` is non-zero: pick from `req`, go to GRANT, load `owner` with the winner, set `cnt` to 0.
- GRANT, release conditions:
  - (a) `req[owner]` is 0 (voluntary release).
  - (b) `cnt` equals SLICE-1 (slice expiry).
  - Otherwise `cnt` increments.
- On voluntary release:
  - Pick from `req` with the owner bit masked.
  - If none remain, go to IDLE with `gnt` cleared.
- On slice expiry:
  - Pick from the full `req`. The owner wins only if it is the sole requester; it is then re-granted and `cnt` resets to 0.
- Handover is back-to-back: the new grant appears in the cycle immediately after the last owner cycle, with no bubble.
- `y` is updated every cycle: `y <= valid_next ? d[sel_next] : 0`.
- Requests arriving or leaving in the same cycle as a release are all considered by that cycle's pick.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state IDLE, `owner` = 3 so the first scan starts at 0, `cnt` = 0, `gnt` = 0, `sel` = 0, `valid` = 0, `y` = 0.
- Reset asserted mid-grant clears all outputs immediately, without waiting for `clk`.
- Request-to-grant latency is 1 cycle: `req` is sampled at edge N and `gnt`/`sel`/`valid` are visible after edge N.
- `y` reflects `d` sampled at the same edge as the grant decision. Its latency is 1 cycle from `d`.
- A grant lasts at most SLICE cycles when other requesters are waiting.
- SLICE = 1: ownership rotates every cycle among the active requesters.
- Grant deassertion lags the `req` drop by 1 cycle. The owner sees one extra granted cycle after dropping `req`.

## Configuration
- `MUX_RR_ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - In GRANT with `lock` = 1 and `req[owner]` = 1, slice expiry is suppressed and `cnt` saturates at SLICE-1.
  - Voluntary release still applies.
  - When `lock` drops, expiry takes effect at the next edge if `cnt` = SLICE-1.
- Not defined: there is no `lock` port, and slice expiry is always enforced.

## Structure
- Package `mux_rr_arb_pkg` holds:
  - The state enum {IDLE, GRANT}.
  - Constants NREQ = 4 and SEL_W = 2.
  - A function converting one-hot to index.
- Sub-module `rr_pick`:
  - Combinational.
  - Inputs: `mask[3:0]` and `start[1:0]`.
  - Outputs: `found` and `idx[1:0]`, using rotate-priority search.
  - Instantiated once; the candidate mask is muxed in by the FSM.

## Test plan
- **Reset and first grant.** Hold `reset_n` = 0 for 10 ns, then set `req` = 4'b1010 → the cycle after sampling, `gnt` = 4'b0010, `sel` = 1, `valid` = 1.
- **Fairness.** `req` = 4'b1111 held, SLICE = 4 → owners follow 0,1,2,3,0, each for exactly 4 cycles, with no idle cycle between them.
- **Voluntary release.** Owner 2 drops `req` after 2 grant cycles while `req[0]` = 1 → grant moves to 0 on the next cycle. `gnt` is never 0 during the handover.
- **Sole requester.** Only `req[3]` = 1 for 20 cycles → `gnt` = 4'b1000 continuously, with `cnt` wrapping every 4 cycles. Toggling `d[3]` each cycle makes `y` follow it with 1-cycle latency.
- **Asynchronous reset mid-grant.** Pulse `reset_n` low between clock edges during a grant → `gnt`, `valid`, and `y` go to 0 before the next edge. After release, the scan starts at requester 0.
- **Lock (`MUX_RR_ARB_LOCK_EN`).** `req` = 4'b0011, owner 0 with `lock` = 1 for 10 cycles → owner 0 keeps the grant for all 10 cycles. When `lock` drops, the grant moves to 1 on the next edge.
